// File: rtl/entity_scan_scheduler_if.sv
// Sprite-line fetch request channel between the entity scheduler and the sprite ROM.
// The master drives the request and the slave returns ready.
interface entity_scan_scheduler_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_sprite_id;
  logic [1:0] req_orientation;
  logic [2:0] req_line;
  logic       req_hit;

  modport master (
    output req_valid, req_sprite_id, req_orientation, req_line, req_hit,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_sprite_id, req_orientation, req_line, req_hit,
    output req_ready
  );
endinterface

// File: rtl/entity_scan_scheduler.sv
// Per-tile entity scheduler: scans nine slots in priority order and issues one sprite-line fetch.
// Optional macro ARRAY_SCAN_EN enables horizontal span matching for slot 6 (entity_7_Array).
//
// state | meaning
// IDLE  | waiting for tile_start
// SCAN  | evaluating one slot per cycle, slot 0 first
// ISSUE | request latched; req_valid held until accepted
module entity_scan_scheduler #(
  parameter int         NUM_SLOTS = 9,
  parameter logic [3:0] EMPTY_ID  = 4'hF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 tile_start,
  input  logic [3:0]           tile_h,
  input  logic [3:0]           tile_v,
  input  logic [2:0]           line_index,
  input  logic [13:0]          entity_1,
  input  logic [13:0]          entity_2,
  input  logic [13:0]          entity_3,
  input  logic [13:0]          entity_4,
  input  logic [13:0]          entity_5,
  input  logic [13:0]          entity_6,
  input  logic [17:0]          entity_7_Array,
  input  logic [13:0]          entity_8_Flip,
  input  logic [13:0]          entity_9_Flip,
  entity_scan_scheduler_if.master req,
  output logic                 scan_busy,
  output logic [7:0]           overrun_count
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  localparam logic [3:0] LAST_SLOT  = 4'(NUM_SLOTS - 1);
  localparam logic [3:0] ARRAY_SLOT = 4'd6;
  localparam logic [3:0] FLIP_SLOT  = 4'd7;

  state_t     state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic [3:0] tile_h_q, tile_h_d;
  logic [3:0] tile_v_q, tile_v_d;
  logic [2:0] line_q, line_d;
  logic       valid_q, valid_d;
  logic [3:0] id_q, id_d;
  logic [1:0] orient_q, orient_d;
  logic [2:0] req_line_q, req_line_d;
  logic       hit_q, hit_d;
  logic [7:0] ovr_q, ovr_d;

  logic [13:0] slot_ent;
  logic [3:0]  cur_id;
  logic [1:0]  cur_orient;
  logic [3:0]  cur_x;
  logic [3:0]  cur_y;
  logic        x_match;
  logic        slot_match;

  // Entities are read live; the slot counter picks which one is examined this cycle.
  always_comb begin
    slot_ent = entity_1;
    case (slot_q)
      4'd0:    slot_ent = entity_1;
      4'd1:    slot_ent = entity_2;
      4'd2:    slot_ent = entity_3;
      4'd3:    slot_ent = entity_4;
      4'd4:    slot_ent = entity_5;
      4'd5:    slot_ent = entity_6;
      4'd6:    slot_ent = entity_7_Array[17:4];
      4'd7:    slot_ent = entity_8_Flip;
      4'd8:    slot_ent = entity_9_Flip;
      default: slot_ent = {EMPTY_ID, 10'd0};
    endcase
  end

  assign cur_id     = slot_ent[13:10];
  assign cur_orient = slot_ent[9:8];
  assign cur_x      = slot_ent[7:4];
  assign cur_y      = slot_ent[3:0];

`ifdef ARRAY_SCAN_EN
  logic [4:0] col_off;
  logic [4:0] span;

  // A negative offset sets bit 4, so the array never wraps past column 15.
  assign col_off = {1'b0, tile_h_q} - {1'b0, cur_x};
  assign span    = (entity_7_Array[3:0] == 4'd0) ? 5'd1 : {1'b0, entity_7_Array[3:0]};
  assign x_match = (slot_q == ARRAY_SLOT) ? (!col_off[4] && (col_off < span))
                                          : (cur_x == tile_h_q);
`else
  logic unused_len;

  assign unused_len = ^entity_7_Array[3:0];
  assign x_match    = (cur_x == tile_h_q);
`endif

  assign slot_match = (cur_id != EMPTY_ID) && x_match && (cur_y == tile_v_q);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      slot_q     <= 4'd0;
      tile_h_q   <= 4'd0;
      tile_v_q   <= 4'd0;
      line_q     <= 3'd0;
      valid_q    <= 1'b0;
      id_q       <= EMPTY_ID;
      orient_q   <= 2'd0;
      req_line_q <= 3'd0;
      hit_q      <= 1'b0;
      ovr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      tile_h_q   <= tile_h_d;
      tile_v_q   <= tile_v_d;
      line_q     <= line_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      orient_q   <= orient_d;
      req_line_q <= req_line_d;
      hit_q      <= hit_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    tile_h_d   = tile_h_q;
    tile_v_d   = tile_v_q;
    line_d     = line_q;
    valid_d    = valid_q;
    id_d       = id_q;
    orient_d   = orient_q;
    req_line_d = req_line_q;
    hit_d      = hit_q;
    ovr_d      = ovr_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
      end
      SCAN: begin
        if (slot_match) begin
          id_d       = cur_id;
          orient_d   = cur_orient;
          req_line_d = (slot_q >= FLIP_SLOT) ? ~line_q : line_q;
          hit_d      = 1'b1;
          state_d    = ISSUE;
        end else if (slot_q == LAST_SLOT) begin
          id_d       = EMPTY_ID;
          orient_d   = 2'd0;
          req_line_d = line_q;
          hit_d      = 1'b0;
          state_d    = ISSUE;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      ISSUE: begin
        // First ISSUE cycle raises valid; later cycles wait for the handshake.
        if (valid_q && req.req_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A new tile always wins, including over a simultaneous handshake.
    if (tile_start) begin
      if (state_q != IDLE && ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
      state_d  = SCAN;
      slot_d   = 4'd0;
      tile_h_d = tile_h;
      tile_v_d = tile_v;
      line_d   = line_index;
      valid_d  = 1'b0;
    end
  end

  assign req.req_valid       = valid_q;
  assign req.req_sprite_id   = id_q;
  assign req.req_orientation = orient_q;
  assign req.req_line        = req_line_q;
  assign req.req_hit         = hit_q;
  assign scan_busy           = (state_q != IDLE);
  assign overrun_count       = ovr_q;

endmodule

// File: tb/tb_entity_scan_scheduler.sv
// Randomized and directed bench for entity_scan_scheduler against a slot-priority reference model.
module tb_entity_scan_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tile_start = 1'b0;
  logic [3:0] tile_h = 4'd0;
  logic [3:0] tile_v = 4'd0;
  logic [2:0] line_index = 3'd0;
  logic       ready = 1'b0;

  logic [3:0] ent_id [9];
  logic [1:0] ent_or [9];
  logic [3:0] ent_x  [9];
  logic [3:0] ent_y  [9];
  logic [3:0] arr_len;

  logic [13:0] entity_1, entity_2, entity_3, entity_4, entity_5, entity_6;
  logic [17:0] entity_7_Array;
  logic [13:0] entity_8_Flip, entity_9_Flip;
  logic        scan_busy;
  logic [7:0]  overrun_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign entity_1       = {ent_id[0], ent_or[0], ent_x[0], ent_y[0]};
  assign entity_2       = {ent_id[1], ent_or[1], ent_x[1], ent_y[1]};
  assign entity_3       = {ent_id[2], ent_or[2], ent_x[2], ent_y[2]};
  assign entity_4       = {ent_id[3], ent_or[3], ent_x[3], ent_y[3]};
  assign entity_5       = {ent_id[4], ent_or[4], ent_x[4], ent_y[4]};
  assign entity_6       = {ent_id[5], ent_or[5], ent_x[5], ent_y[5]};
  assign entity_7_Array = {ent_id[6], ent_or[6], ent_x[6], ent_y[6], arr_len};
  assign entity_8_Flip  = {ent_id[7], ent_or[7], ent_x[7], ent_y[7]};
  assign entity_9_Flip  = {ent_id[8], ent_or[8], ent_x[8], ent_y[8]};

  entity_scan_scheduler_if bus ();
  assign bus.req_ready = ready;

  entity_scan_scheduler dut (
    .clk_in         (clk),
    .reset          (rst_n),
    .tile_start     (tile_start),
    .tile_h         (tile_h),
    .tile_v         (tile_v),
    .line_index     (line_index),
    .entity_1       (entity_1),
    .entity_2       (entity_2),
    .entity_3       (entity_3),
    .entity_4       (entity_4),
    .entity_5       (entity_5),
    .entity_6       (entity_6),
    .entity_7_Array (entity_7_Array),
    .entity_8_Flip  (entity_8_Flip),
    .entity_9_Flip  (entity_9_Flip),
    .req            (bus.master),
    .scan_busy      (scan_busy),
    .overrun_count  (overrun_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which slot wins for the given tile (9 = no hit).
  function automatic bit slot_hits(int s, logic [3:0] h, logic [3:0] v);
    int lenv;
    if (ent_id[s] == 4'hF || ent_y[s] != v) return 1'b0;
`ifdef ARRAY_SCAN_EN
    if (s == 6) begin
      lenv = (arr_len == 4'd0) ? 1 : int'(arr_len);
      return (int'(h) >= int'(ent_x[6])) && (int'(h) < int'(ent_x[6]) + lenv);
    end
`endif
    lenv = 0;
    return (ent_x[s] == h) && (lenv == 0);
  endfunction

  function automatic int winner(logic [3:0] h, logic [3:0] v);
    for (int s = 0; s < 9; s++) begin
      if (slot_hits(s, h, v)) return s;
    end
    return 9;
  endfunction

  int w_now;
  always_comb w_now = winner(tile_h, tile_v);

  // Model state: busy from tile_start until accepted; valid after (winner+2) or 10 edges.
  int         m_busy, m_valid, m_rem, m_cnt;
  logic [3:0] m_id;
  logic [1:0] m_or;
  logic [2:0] m_line;
  logic       m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_valid <= 0; m_rem <= 0; m_cnt <= 0;
      m_id <= 4'hF; m_or <= 2'd0; m_line <= 3'd0; m_hit <= 1'b0;
    end else if (tile_start) begin
      if (m_busy != 0) m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      m_busy  <= 1;
      m_valid <= 0;
      m_rem   <= (w_now == 9) ? 10 : w_now + 2;
      m_hit   <= (w_now != 9);
      m_id    <= (w_now == 9) ? 4'hF : ent_id[w_now];
      m_or    <= (w_now == 9) ? 2'd0 : ent_or[w_now];
      m_line  <= (w_now >= 7 && w_now < 9) ? 3'(7 - int'(line_index)) : line_index;
    end else if (m_valid != 0 && ready) begin
      m_busy  <= 0;
      m_valid <= 0;
    end else if (m_busy != 0 && m_valid == 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_valid <= 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_valid", int'(bus.req_valid), m_valid);
      chk("scan_busy", int'(scan_busy), m_busy);
      chk("overrun_count", int'(overrun_count), m_cnt);
      if (m_valid != 0) begin
        chk("req_sprite_id", int'(bus.req_sprite_id), int'(m_id));
        chk("req_hit", int'(bus.req_hit), int'(m_hit));
        chk("req_line", int'(bus.req_line), int'(m_line));
        if (m_hit) chk("req_orientation", int'(bus.req_orientation), int'(m_or));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_ents();
    for (int s = 0; s < 9; s++) begin
      ent_id[s] = 4'hF; ent_or[s] = 2'd0; ent_x[s] = 4'd0; ent_y[s] = 4'd0;
    end
    arr_len = 4'd0;
  endtask

  task automatic set_ent(input int s, input logic [3:0] id, input logic [1:0] o,
                         input logic [3:0] x, input logic [3:0] y);
    ent_id[s] = id; ent_or[s] = o; ent_x[s] = x; ent_y[s] = y;
  endtask

  task automatic pulse_start(input logic [3:0] h, input logic [3:0] v, input logic [2:0] l);
    tile_h = h; tile_v = v; line_index = l; tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
  endtask

  // Issues one tile with ready=1 and reports the edge at which req_valid first rose.
  task automatic run_req(input logic [3:0] h, input logic [3:0] v, input logic [2:0] l,
                         output int rise, output int id, output int o,
                         output int line, output int hit);
    rise = -1; id = -1; o = -1; line = -1; hit = -1;
    ready = 1'b1;
    pulse_start(h, v, l);
    for (int e = 0; e < 14; e++) begin
      neg(1);
      if (bus.req_valid && rise < 0) begin
        rise = e; id = int'(bus.req_sprite_id); o = int'(bus.req_orientation);
        line = int'(bus.req_line); hit = int'(bus.req_hit);
      end
    end
    tick();
  endtask

  int rise, rid, ror, rline, rhit;

  initial begin
    clear_ents();
    neg(1);
    chk("reset req_valid", int'(bus.req_valid), 0);
    chk("reset req_sprite_id", int'(bus.req_sprite_id), 15);
    chk("reset scan_busy", int'(scan_busy), 0);
    chk("reset overrun_count", int'(overrun_count), 0);
    chk("reset req_hit", int'(bus.req_hit), 0);
    tick();
    rst_n = 1'b1;
    tick();

    set_ent(0, 4'd3, 2'd1, 4'd5, 4'd2);
    run_req(4'd5, 4'd2, 3'd4, rise, rid, ror, rline, rhit);
    chk("t1 rise edge", rise, 2);
    chk("t1 id", rid, 3);
    chk("t1 orient", ror, 1);
    chk("t1 line", rline, 4);
    chk("t1 hit", rhit, 1);

    clear_ents();
    set_ent(1, 4'd6, 2'd2, 4'd7, 4'd1);
    set_ent(8, 4'd9, 2'd3, 4'd7, 4'd1);
    run_req(4'd7, 4'd1, 3'd2, rise, rid, ror, rline, rhit);
    chk("t2 priority rise", rise, 3);
    chk("t2 priority id", rid, 6);
    chk("t2 priority line", rline, 2);
    ent_id[1] = 4'hF;
    run_req(4'd7, 4'd1, 3'd2, rise, rid, ror, rline, rhit);
    chk("t2 flip rise", rise, 10);
    chk("t2 flip id", rid, 9);
    chk("t2 flip line", rline, 5);

    clear_ents();
    set_ent(0, 4'd2, 2'd0, 4'd1, 4'd1);
    run_req(4'd9, 4'd9, 3'd3, rise, rid, ror, rline, rhit);
    chk("t3 miss rise", rise, 10);
    chk("t3 miss id", rid, 15);
    chk("t3 miss hit", rhit, 0);
    chk("t3 miss line", rline, 3);

    // Backpressure: ready low for several cycles after the request appears.
    clear_ents();
    set_ent(0, 4'd2, 2'd3, 4'd5, 4'd2);
    ready = 1'b0;
    pulse_start(4'd5, 4'd2, 3'd6);
    neg(1);
    repeat (6) tick();
    neg(1);
    chk("t4 held valid", int'(bus.req_valid), 1);
    chk("t4 held id", int'(bus.req_sprite_id), 2);
    tick();
    ready = 1'b1;
    neg(1);
    chk("t4 still valid", int'(bus.req_valid), 1);
    neg(1);
    chk("t4 accepted valid", int'(bus.req_valid), 0);
    chk("t4 idle busy", int'(scan_busy), 0);
    tick();

    // Overrun: second tile_start four cycles after the first.
    clear_ents();
    set_ent(0, 4'd3, 2'd0, 4'd5, 4'd2);
    pulse_start(4'd3, 4'd3, 3'd0);
    repeat (3) tick();
    pulse_start(4'd5, 4'd2, 3'd1);
    neg(1);
    chk("t5 overrun count", int'(overrun_count), 1);
    chk("t5 overrun valid", int'(bus.req_valid), 0);
    neg(2);
    chk("t5 restart hit", int'(bus.req_valid), 1);
    tick();
    tile_start = 1'b1;
    repeat (301) tick();
    tile_start = 1'b0;
    neg(1);
    chk("t5 saturate", int'(overrun_count), 255);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    clear_ents();
    set_ent(6, 4'd7, 2'd2, 4'd4, 4'd3);
    arr_len = 4'd3;
`ifdef ARRAY_SCAN_EN
    run_req(4'd6, 4'd3, 3'd5, rise, rid, ror, rline, rhit);
    chk("array in-span rise", rise, 8);
    chk("array in-span id", rid, 7);
    chk("array in-span line", rline, 5);
    run_req(4'd7, 4'd3, 3'd5, rise, rid, ror, rline, rhit);
    chk("array past-span rise", rise, 10);
    chk("array past-span id", rid, 15);
`else
    run_req(4'd6, 4'd3, 3'd5, rise, rid, ror, rline, rhit);
    chk("array off-x rise", rise, 10);
    chk("array off-x id", rid, 15);
    run_req(4'd4, 4'd3, 3'd5, rise, rid, ror, rline, rhit);
    chk("array exact rise", rise, 8);
    chk("array exact id", rid, 7);
`endif

    // Random traffic; entities only change while the model is idle.
    for (int c = 0; c < 4000; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      tile_start = 1'b0;
      if (m_busy == 0 && $urandom_range(0, 3) == 0) begin
        for (int s = 0; s < 9; s++) begin
          ent_id[s] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
          ent_or[s] = 2'($urandom_range(0, 3));
          ent_x[s]  = 4'($urandom_range(0, 3));
          ent_y[s]  = 4'($urandom_range(0, 3));
        end
        arr_len = 4'($urandom_range(0, 3));
        tile_h = 4'($urandom_range(0, 4));
        tile_v = 4'($urandom_range(0, 4));
        line_index = 3'($urandom_range(0, 7));
        tile_start = 1'b1;
      end else if (m_busy != 0 && $urandom_range(0, 29) == 0) begin
        tile_h = 4'($urandom_range(0, 4));
        tile_v = 4'($urandom_range(0, 4));
        line_index = 3'($urandom_range(0, 7));
        tile_start = 1'b1;
      end
      tick();
    end
    tile_start = 1'b0;
    ready = 1'b1;
    repeat (16) tick();

    // Reset in the middle of a scan.
    clear_ents();
    pulse_start(4'd1, 4'd1, 3'd7);
    repeat (3) tick();
    rst_n = 1'b0;
    neg(1);
    chk("midreset valid", int'(bus.req_valid), 0);
    chk("midreset busy", int'(scan_busy), 0);
    chk("midreset count", int'(overrun_count), 0);
    chk("midreset id", int'(bus.req_sprite_id), 15);
    chk("midreset line", int'(bus.req_line), 0);
    chk("midreset orient", int'(bus.req_orientation), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/entity_scan_scheduler.md
Name: entity_scan_scheduler

Overview:
- Per-tile entity scheduler ahead of the sprite ROM in the frame buffer path.
- On each tile-start pulse, scans the nine entity slots in priority order against the upcoming tile coordinate.
- Picks the highest-priority matching entity and issues exactly one sprite-line fetch request (ID, orientation, line) over a valid/ready handshake.
- Replaces the free-running entity counter and inRange logic with a bounded, deterministic sequence.

Parameters:
- NUM_SLOTS, 9, entity slots scanned per tile; fixed slot map below.
- EMPTY_ID, 4'hF, sprite ID marking an unused slot and a "no hit" request.

Ports:
- clk_in  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tile_start  in  1  one-cycle pulse; begin scan for a new tile
- tile_h  in  4  target tile column, sampled on tile_start
- tile_v  in  4  target tile row, sampled on tile_start
- line_index  in  3  row within tile (0-7), sampled on tile_start
- entity_1 .. entity_6  in  14 each  [13:10] ID, [9:8] orientation, [7:4] X, [3:0] Y
- entity_7_Array  in  18  [17:14] ID, [13:12] orient, [11:8] X, [7:4] Y, [3:0] length
- entity_8_Flip, entity_9_Flip  in  14 each  same format as entity_1; line is vertically flipped
- req_valid  out  1  fetch request valid
- req_ready  in  1  ROM side accepts request
- req_sprite_id  out  4  sprite ID; EMPTY_ID on miss
- req_orientation  out  2  orientation of winning entity
- req_line  out  3  line index, inverted for flip slots
- req_hit  out  1  1 = an entity matched
- scan_busy  out  1  high in SCAN or ISSUE
- overrun_count  out  8  saturating count of aborted scans

Behaviour:
- Reset (reset=0, async): state IDLE; req_valid=0, req_hit=0, req_sprite_id=4'hF, req_orientation=0, req_line=0, scan_busy=0, overrun_count=0, slot counter=0.
- Slot order and priority: slot0=entity_1 (highest) .. slot5=entity_6, slot6=entity_7_Array, slot7=entity_8_Flip, slot8=entity_9_Flip (lowest).
- Entity inputs are read live during SCAN; they are not snapshotted.
- FSM states: IDLE, SCAN, ISSUE.
- IDLE -> SCAN on tile_start:
  - latch tile_h, tile_v, line_index;
  - slot counter=0.
- SCAN: one slot per cycle.
  - Match condition: ID != EMPTY_ID and X==tile_h and Y==tile_v (4-bit equality).
  - First match: latch ID, orientation and line (~line for slots 7-8), set hit=1, go to ISSUE immediately. Lower-priority slots are not evaluated.
  - After slot 8 with no match: latch sprite_id=EMPTY_ID, hit=0, line unmodified, go to ISSUE.
- Latency: tile_start sampled at edge 0; slot k is evaluated in the cycle after edge k; req_valid rises at edge k+2. Worst case (miss) rises at edge 10.
- ISSUE: req_valid=1 with all req_* fields stable until req_valid and req_ready are both high at an edge, then return to IDLE with req_valid=0.
  - req_ready is ignored outside ISSUE.
- Overrun (tile_start while in SCAN or ISSUE):
  - abort the current operation;
  - req_valid drops at the same edge — the only allowed withdrawal of a valid request;
  - re-latch coordinates and restart SCAN at slot 0;
  - overrun_count += 1, saturating at 255.
- tile_start coinciding with a handshake in ISSUE: counts as overrun; the old request is considered accepted.
- scan_busy = (state != IDLE).
- Reset mid-operation aborts immediately to the reset values.

Optional Feature:
- Macro ARRAY_SCAN_EN.
- Defined: slot 6 matches when Y==tile_v and tile_h-X, computed in 5 bits, is in [0, len-1].
  - len 0 is treated as 1.
  - No wrap past column 15.
- Undefined: slot 6 matches only X==tile_h; length field is ignored.

Test Plan:
- entity_1 ID=3, or=1, X=5, Y=2; all other slots ID=F; tile_start h=5, v=2, line=4, ready=1 -> req_valid at edge 2; id=3, or=1, line=4, hit=1; one accept.
- entity_2 and entity_9_Flip both at (7,1), line=2 -> entity_2 wins, line=2. Then entity_2 ID=F -> entity_9 wins with line=5.
- No matching slots -> req_valid at edge 10; id=F, hit=0.
- Hit at slot 0, ready held 0 for 5 cycles -> req fields stable; single accept when ready=1; state returns to IDLE.
- Second tile_start 4 cycles after the first -> scan restarts, overrun_count=1. After 300 overruns -> overrun_count=255.
- ARRAY_SCAN_EN defined; entity_7 X=4, Y=3, len=3; tile (6,3) hit, (7,3) miss. Undefined: (6,3) miss, (4,3) hit.
